counter_gen: RTL and testbench
==============================

// Module: counter_gen
// PURPOSE
//   Parametrised successor to the fixed 8-bit load/start-stop counter.
//   Adds configurable width, a clock prescaler, up/down direction, a programmable limit,
//   wrap/saturate/one-shot modes and a terminal-count pulse.
//   Used as the general timing/event counter in simple_verilog_designs datapaths.
// PARAMETERS
//   WIDTH       8   counter, load-data and limit width in bits
//   PRESCALE_W  4   width of the prescaler divide input
// PORTS
//   clk      in   1           single clock; everything updates on its rising edge
//   clr      in   1           asynchronous reset, active-low
//   l        in   1           synchronous load: c <= d
//   s_s      in   1           start/stop: 1 = run, 0 = hold
//   up_dn    in   1           1 = count up, 0 = count down
//   mode     in   2           00 = wrap, 01 = saturate, 10 = one-shot, 11 = wrap
//   limit    in   WIDTH       boundary value; up counts 0..limit, down counts limit..0
//   div      in   PRESCALE_W  count step every div+1 clk cycles (0 = every cycle)
//   d        in   WIDTH       load data
//   c        out  WIDTH       counter value
//   tc       out  1           terminal-count pulse, one clk wide
//   running  out  1           1 while the FSM is in RUN
// BEHAVIOUR
//   Reset (clr=0, async): c=0, tc=0, running=0, prescaler=0, state=IDLE.
//   Priority: clr > l > count step.
//   Load:
//     - l=1 sets c=d and clears the prescaler on the next edge, in any state.
//     - A load in DONE returns the FSM to IDLE.
//     - A load never raises tc, even when d equals the boundary.
//   Prescaler:
//     - Advances only in RUN.
//     - tick=1 in the cycle where prescaler==div; the prescaler then returns to 0.
//     - In IDLE it holds its value, so it resumes where it stopped.
//   FSM:
//     - IDLE->RUN when s_s=1.
//     - RUN->IDLE when s_s=0; c holds.
//     - RUN->DONE on a one-shot boundary step.
//     - DONE holds c until l=1 or reset; s_s has no effect in DONE.
//   Count step (RUN and tick and not l):
//     - Up, c<limit: c+1.
//     - Up, c>=limit: wrap -> 0; saturate -> hold; one-shot -> hold and enter DONE.
//     - Down, c>0: c-1.
//     - Down, c==0: wrap -> limit; saturate and one-shot as for up.
//     - Arithmetic is modulo 2^WIDTH. There is no overflow past 2^WIDTH-1 because
//       limit <= 2^WIDTH-1.
//   tc:
//     - Registered. High for one cycle when a count step makes c equal the boundary:
//       limit when counting up, 0 when counting down.
//     - A step that wraps away from the boundary does not pulse.
//     - Saturated holds do not re-pulse.
//   Direction, mode, limit and div are sampled at every tick. A change takes effect at
//   the next tick with no pipeline flush.
//   Latency: c changes on the edge after the tick cycle; tc aligns with that new c.
//   limit=0: up wrap stays at 0 and pulses tc on each tick.
// STRUCTURE
//   Shared package counter_pkg:
//     - mode constants MODE_WRAP, MODE_SAT, MODE_ONESHOT
//     - state encodings S_IDLE, S_RUN, S_DONE
//   Sub-module counter_prescale:
//     - ports clk, clr, en, clear, div -> tick
//     - en = RUN; clear = l
//   Top level: FSM, next-count mux and tc register.
// TESTING
//   1. clr=0 pulse mid-count at c=8'h5A -> c=0, tc=0 and running=0 immediately,
//      with no clk edge needed.
//   2. WIDTH=8, div=0, up, wrap, limit=8'h05, s_s=1 -> c cycles 0,1..5,0;
//      tc high only in the cycle c first reads 5.
//   3. div=3, up, saturate, limit=8'h03 -> c steps every 4 clk cycles, reaches 3,
//      holds; exactly one tc pulse.
//   4. Down, one-shot, l=1 with d=8'h04 -> c counts 4,3,2,1,0 then DONE; running=0;
//      s_s toggling has no effect; l with d=8'h02 returns the FSM to IDLE.
//   5. s_s=0 at c=7, held for 10 cycles, then s_s=1 -> c holds at 7, then resumes at 8;
//      prescaler phase is preserved.
//   6. l=1 while a tick is pending, with d=8'hF0 -> c=F0, no tc; the up count then
//      wraps to 0 because c>=limit.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the general-purpose timing/event counter.
package counter_pkg;

  // Boundary behaviour selected by the mode input.
  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_WRAP_ALT = 2'b11;

  // Counter control states.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Both 00 and 11 behave as wrap.
  function automatic logic mode_is_wrap(input logic [1:0] mode);
    return (mode == MODE_WRAP) || (mode == MODE_WRAP_ALT);
  endfunction

  // One-shot is the only mode that leaves RUN on its own.
  function automatic logic mode_is_oneshot(input logic [1:0] mode);
    return mode == MODE_ONESHOT;
  endfunction

endpackage

// File: rtl/counter_prescale.sv
// Clock prescaler: emits a one-cycle tick every div+1 enabled cycles.
module counter_prescale #(
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] PreOne = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] pre_q, pre_d;

  // Tick when the phase reaches div; phase is frozen while disabled so a
  // stop/start resumes mid-period.
  always_comb begin
    tick  = en && (pre_q == div);
    pre_d = pre_q;
    if (clear) begin
      pre_d = '0;
    end else if (tick) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = pre_q + PreOne;
    end
  end

  // Phase register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/counter_gen.sv
// Parametrised load/start-stop counter with prescaler, direction, limit,
// wrap/saturate/one-shot modes and a registered terminal-count pulse.
module counter_gen
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  l,
  input  logic                  s_s,
  input  logic                  up_dn,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] div,
  input  logic [WIDTH-1:0]      d,
  output logic [WIDTH-1:0]      c,
  output logic                  tc,
  output logic                  running
);

  localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             tc_q, tc_d;

  logic             in_run;
  logic             tick;
  logic             step;
  logic             at_bound;
  logic             hold;
  logic [WIDTH-1:0] boundary;
  logic [WIDTH-1:0] stepped;

  assign in_run = (state_q == S_RUN);

  counter_prescale #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescale (
    .clk  (clk),
    .clr  (clr),
    .en   (in_run),
    .clear(l),
    .div  (div),
    .tick (tick)
  );

  // Boundary detection and candidate next value for a count step.
  always_comb begin
    step     = in_run && tick && !l;
    // Up treats anything at or above limit as the boundary, so an out-of-range
    // load wraps back into range on the first step.
    at_bound = up_dn ? (c_q >= limit) : (c_q == '0);
    boundary = up_dn ? limit : '0;
    hold     = at_bound && !mode_is_wrap(mode);
    if (at_bound) begin
      stepped = up_dn ? '0 : limit;
    end else begin
      stepped = up_dn ? (c_q + CntOne) : (c_q - CntOne);
    end
  end

  // Next count value and terminal-count pulse; load has priority and never pulses.
  always_comb begin
    c_d  = c_q;
    tc_d = 1'b0;
    if (l) begin
      c_d = d;
    end else if (step && !hold) begin
      c_d  = stepped;
      tc_d = (stepped == boundary);
    end
  end

  // Control FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (s_s) state_d = S_RUN;
      end
      S_RUN: begin
        if (step && hold && mode_is_oneshot(mode)) begin
          state_d = S_DONE;
        end else if (!s_s) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (l) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, count and tc registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      tc_q    <= tc_d;
    end
  end

  assign c       = c_q;
  assign tc      = tc_q;
  assign running = in_run;

endmodule

// File: tb/tb_counter_gen.sv
// Self-checking bench for counter_gen: directed table, corner sequences and
// randomized stimulus against a behavioural model.
module tb_counter_gen;

  localparam int W = 8;
  localparam int P = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic         clk = 1'b0;
  logic         clr;
  logic         l;
  logic         s_s;
  logic         up_dn;
  logic [1:0]   mode;
  logic [W-1:0] limit;
  logic [P-1:0] div;
  logic [W-1:0] d;
  logic [W-1:0] c;
  logic         tc;
  logic         running;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state.
  int m_c, m_pre, m_st, m_tc;

  counter_gen #(
    .WIDTH     (W),
    .PRESCALE_W(P)
  ) dut (
    .clk    (clk),
    .clr    (clr),
    .l      (l),
    .s_s    (s_s),
    .up_dn  (up_dn),
    .mode   (mode),
    .limit  (limit),
    .div    (div),
    .d      (d),
    .c      (c),
    .tc     (tc),
    .running(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_c = 0; m_pre = 0; m_st = M_IDLE; m_tc = 0;
  endtask

  // One clock edge of the specified behaviour, using current inputs.
  task automatic model_edge();
    int  bnd, lim;
    bit  moved, done, tk;
    lim   = int'(limit);
    m_tc  = 0;
    moved = 0;
    done  = 0;
    if (l) begin
      m_c   = int'(d);
      m_pre = 0;
      if (m_st == M_DONE) m_st = M_IDLE;
      else m_st = s_s ? M_RUN : M_IDLE;
    end else if (m_st == M_IDLE) begin
      if (s_s) m_st = M_RUN;
    end else if (m_st == M_RUN) begin
      tk    = (m_pre == int'(div));
      m_pre = tk ? 0 : (m_pre + 1) % (1 << P);
      if (tk) begin
        bnd = up_dn ? lim : 0;
        if (up_dn && m_c < lim) begin
          m_c = m_c + 1; moved = 1;
        end else if (!up_dn && m_c > 0) begin
          m_c = m_c - 1; moved = 1;
        end else if (mode == 2'b00 || mode == 2'b11) begin
          m_c = up_dn ? 0 : lim; moved = 1;
        end else if (mode == 2'b10) begin
          done = 1;
        end
        if (moved && m_c == bnd) m_tc = 1;
      end
      if (done) m_st = M_DONE;
      else if (!s_s) m_st = M_IDLE;
    end
  endtask

  // Advance one clock and compare DUT against model.
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check("c", int'(c), m_c);
    check("tc", int'(tc), m_tc);
    check("running", int'(running), int'(m_st == M_RUN));
  endtask

  task automatic set_in(input bit il, input bit iss, input bit iup, input logic [1:0] im,
                        input logic [W-1:0] ilim, input logic [P-1:0] idiv,
                        input logic [W-1:0] id);
    l = il; s_s = iss; up_dn = iup; mode = im; limit = ilim; div = idiv; d = id;
  endtask

  typedef struct {
    bit           l;
    bit           s_s;
    bit           up;
    logic [1:0]   mode;
    logic [W-1:0] limit;
    logic [P-1:0] div;
    logic [W-1:0] d;
    int           exp_c;
    int           exp_tc;
    int           exp_run;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int tc_cnt;
    int guard;

    clr = 1'b0;
    set_in(0, 0, 1, 2'b00, 8'h00, 4'h0, 8'h00);
    model_reset();
    #12;
    check("reset_c", int'(c), 0);
    check("reset_tc", int'(tc), 0);
    check("reset_running", int'(running), 0);
    clr = 1'b1;

    // Up/wrap through limit 5 at full rate.
    tbl.push_back('{1, 1, 1, 2'b00, 8'h05, 4'h0, 8'h00, 0, 0, 1});
    tbl.push_back('{0, 1, 1, 2'b00, 8'h05, 4'h0, 8'h00, 1, 0, 1});
    tbl.push_back('{0, 1, 1, 2'b00, 8'h05, 4'h0, 8'h00, 2, 0, 1});
    tbl.push_back('{0, 1, 1, 2'b00, 8'h05, 4'h0, 8'h00, 3, 0, 1});
    tbl.push_back('{0, 1, 1, 2'b00, 8'h05, 4'h0, 8'h00, 4, 0, 1});
    tbl.push_back('{0, 1, 1, 2'b00, 8'h05, 4'h0, 8'h00, 5, 1, 1});
    tbl.push_back('{0, 1, 1, 2'b00, 8'h05, 4'h0, 8'h00, 0, 0, 1});
    tbl.push_back('{0, 1, 1, 2'b00, 8'h05, 4'h0, 8'h00, 1, 0, 1});
    foreach (tbl[i]) begin
      set_in(tbl[i].l, tbl[i].s_s, tbl[i].up, tbl[i].mode, tbl[i].limit, tbl[i].div, tbl[i].d);
      cyc();
      check("tbl_c", int'(c), tbl[i].exp_c);
      check("tbl_tc", int'(tc), tbl[i].exp_tc);
      check("tbl_running", int'(running), tbl[i].exp_run);
    end

    // Asynchronous clear mid-count without a clock edge.
    set_in(1, 1, 1, 2'b00, 8'hFF, 4'h0, 8'h5A);
    cyc();
    check("load_5a", int'(c), 'h5A);
    l = 1'b0;
    #2;
    clr = 1'b0;
    #1;
    check("async_c", int'(c), 0);
    check("async_tc", int'(tc), 0);
    check("async_running", int'(running), 0);
    model_reset();
    #2;
    clr = 1'b1;

    // Saturate with div=3: one tc, settles at 3.
    set_in(1, 1, 1, 2'b01, 8'h03, 4'h3, 8'h00);
    cyc();
    l = 1'b0;
    tc_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      cyc();
      if (tc) tc_cnt++;
    end
    check("sat_c", int'(c), 3);
    check("sat_tc_count", tc_cnt, 1);

    // Stop at 7 for 10 cycles, then resume to 8.
    set_in(1, 1, 1, 2'b00, 8'hFF, 4'h1, 8'h00);
    cyc();
    l = 1'b0;
    guard = 0;
    while (m_c != 7 && guard < 100) begin
      cyc();
      guard++;
    end
    check("reach7_in_budget", int'(guard < 100), 1);
    s_s = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    check("stop_hold_c", int'(c), 7);
    check("stop_running", int'(running), 0);
    s_s = 1'b1;
    guard = 0;
    while (c == 8'h07 && guard < 20) begin
      cyc();
      guard++;
    end
    check("resume_c", int'(c), 8);

    // Down one-shot from 4, DONE ignores s_s, load returns to IDLE.
    set_in(1, 1, 0, 2'b10, 8'h09, 4'h0, 8'h04);
    cyc();
    l = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check("oneshot_zero_c", int'(c), 0);
    check("oneshot_zero_tc", int'(tc), 1);
    cyc();
    check("done_running", int'(running), 0);
    check("done_tc", int'(tc), 0);
    for (int i = 0; i < 6; i++) begin
      s_s = i[0];
      cyc();
    end
    check("done_hold_c", int'(c), 0);
    check("done_hold_running", int'(running), 0);
    set_in(1, 0, 0, 2'b10, 8'h09, 4'h0, 8'h02);
    cyc();
    check("reload_c", int'(c), 2);
    l = 1'b0;
    cyc();
    check("idle_after_reload", int'(running), 0);
    check("idle_hold_c", int'(c), 2);

    // Load F0 mid-period: no tc, next step wraps to 0 since F0 >= limit.
    set_in(1, 1, 1, 2'b00, 8'h05, 4'h2, 8'h00);
    cyc();
    l = 1'b0;
    cyc();
    set_in(1, 1, 1, 2'b00, 8'h05, 4'h2, 8'hF0);
    cyc();
    check("load_f0_c", int'(c), 'hF0);
    check("load_f0_tc", int'(tc), 0);
    l = 1'b0;
    guard = 0;
    while (c == 8'hF0 && guard < 20) begin
      cyc();
      guard++;
    end
    check("wrap_from_f0_c", int'(c), 0);
    check("wrap_from_f0_tc", int'(tc), 0);

    // limit=0 up wrap: stays 0, pulses every tick.
    set_in(1, 1, 1, 2'b00, 8'h00, 4'h0, 8'h00);
    cyc();
    l = 1'b0;
    cyc();
    check("lim0_c", int'(c), 0);
    check("lim0_tc", int'(tc), 1);
    cyc();
    check("lim0_tc_again", int'(tc), 1);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      l     = ($urandom_range(0, 15) == 0);
      s_s   = ($urandom_range(0, 7) != 0);
      d     = W'($urandom);
      if ($urandom_range(0, 15) == 0) up_dn = 1'($urandom);
      if ($urandom_range(0, 15) == 0) mode  = 2'($urandom);
      if ($urandom_range(0, 31) == 0) limit = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 9))
                                                                          : W'($urandom);
      if ($urandom_range(0, 63) == 0) div   = P'($urandom_range(0, 3));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
